// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
package mult_div_pkg;

   localparam int DATA_W  = 32;
   localparam int ITERS   = DATA_W;
   localparam int COUNT_W = 6;

   // Most negative 32-bit value; the one quotient that cannot be negated.
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      DIV    = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into
// the accumulator, then an arithmetic right shift of {acc, q, q_-1}.
module booth_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] q,
   input  logic         q_m1,
   input  logic [W-1:0] mcand,
   output logic [W-1:0] acc_out,
   output logic [W-1:0] q_out,
   output logic         q_m1_out
);

   // One guard bit keeps the add/sub exact; acc - MIN_INT would otherwise
   // overflow and flip the sign shifted back in.
   logic [W:0] acc_ext;
   logic [W:0] mcand_ext;
   logic [W:0] sum;

   assign acc_ext   = {acc[W-1], acc};
   assign mcand_ext = {mcand[W-1], mcand};

   // Booth recoding on the pair {q[0], q_-1}: 01 adds, 10 subtracts.
   always_comb begin
      sum = acc_ext;
      case ({q[0], q_m1})
         2'b01:   sum = acc_ext + mcand_ext;
         2'b10:   sum = acc_ext - mcand_ext;
         default: sum = acc_ext;
      endcase
   end

   // Arithmetic shift: the true sign (guard bit) enters the accumulator top.
   assign acc_out  = sum[W:1];
   assign q_out    = {sum[0], q[W-1:1]};
   assign q_m1_out = q[0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth) / divide (restoring) unit feeding HI/LO.
// A start is accepted only in IDLE; results appear with a one-cycle done.
module mult_div_unit #(
   parameter int DATA_W = 32,
   parameter int ITERS  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_mult,
   input  logic              start_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              div_zero
);
   import mult_div_pkg::*;

   state_t               state_reg, state_next;
   logic [COUNT_W-1:0]   count_reg;
   logic [DATA_W-1:0]    acc_reg;      // Booth accumulator / divider remainder
   logic [DATA_W-1:0]    q_reg;        // multiplier / dividend-then-quotient
   logic                 q_m1_reg;
   logic [DATA_W-1:0]    mcand_reg;    // multiplicand / divisor magnitude
   logic                 is_div_reg;
   logic                 neg_q_reg;
   logic                 neg_r_reg;
   logic                 dz_reg;
   logic [DATA_W-1:0]    hi_reg, lo_reg;
   logic                 busy_reg, done_reg, div_zero_reg;
   logic                 done_next, div_zero_next;
   logic                 accept, last_iter;

   // The done cycle still counts as busy, so no start is taken in it.
   assign accept    = (state_reg == IDLE) && !done_reg;
   assign last_iter = (count_reg == COUNT_W'(ITERS - 1));

   logic [DATA_W-1:0] booth_acc, booth_q;
   logic              booth_q_m1;

   booth_step #(.W(DATA_W)) u_booth (
      .acc      (acc_reg),
      .q        (q_reg),
      .q_m1     (q_m1_reg),
      .mcand    (mcand_reg),
      .acc_out  (booth_acc),
      .q_out    (booth_q),
      .q_m1_out (booth_q_m1)
   );

   // Restoring divide step: shift in the next dividend bit, keep the
   // trial difference only when it did not go negative.
   logic [DATA_W:0]   rem_sh, trial;
   logic              fits;
   logic [DATA_W-1:0] rem_next, quo_next;
   assign rem_sh   = {acc_reg, q_reg[DATA_W-1]};
   assign fits     = (rem_sh >= {1'b0, mcand_reg});
   assign trial    = rem_sh - {1'b0, mcand_reg};
   assign rem_next = fits ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
   assign quo_next = {q_reg[DATA_W-2:0], fits};

   // Sign correction: quotient truncates toward zero, remainder follows a.
   logic [DATA_W-1:0] quo_fix, rem_fix;
   assign quo_fix = neg_q_reg ? (DATA_W'(0) - q_reg)   : q_reg;
   assign rem_fix = neg_r_reg ? (DATA_W'(0) - acc_reg) : acc_reg;

   // Next-state and registered-output decode.
   always_comb begin
      state_next    = state_reg;
      done_next     = 1'b0;
      div_zero_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept && start_mult)
               state_next = MULT;
            else if (accept && start_div)
               state_next = (b == '0) ? FINISH : DIV;
         end
         MULT, DIV: begin
            if (last_iter)
               state_next = FINISH;
         end
         FINISH: begin
            state_next    = IDLE;
            done_next     = 1'b1;
            div_zero_next = dz_reg;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and handshake registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         busy_reg     <= (state_next != IDLE) || (state_reg == FINISH);
         done_reg     <= done_next;
         div_zero_reg <= div_zero_next;
      end
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg  <= '0;
         acc_reg    <= '0;
         q_reg      <= '0;
         q_m1_reg   <= 1'b0;
         mcand_reg  <= '0;
         is_div_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept && (start_mult || start_div)) begin
                  count_reg <= '0;
                  acc_reg   <= '0;
                  q_m1_reg  <= 1'b0;
                  if (start_mult) begin
                     q_reg      <= b;
                     mcand_reg  <= a;
                     is_div_reg <= 1'b0;
                     neg_q_reg  <= 1'b0;
                     neg_r_reg  <= 1'b0;
                     dz_reg     <= 1'b0;
                  end else begin
                     q_reg      <= a[DATA_W-1] ? (DATA_W'(0) - a) : a;
                     mcand_reg  <= b[DATA_W-1] ? (DATA_W'(0) - b) : b;
                     is_div_reg <= 1'b1;
                     neg_q_reg  <= a[DATA_W-1] ^ b[DATA_W-1];
                     neg_r_reg  <= a[DATA_W-1];
                     dz_reg     <= (b == '0);
                  end
               end
            end
            MULT: begin
               acc_reg   <= booth_acc;
               q_reg     <= booth_q;
               q_m1_reg  <= booth_q_m1;
               count_reg <= count_reg + 1'b1;
            end
            DIV: begin
               acc_reg   <= rem_next;
               q_reg     <= quo_next;
               count_reg <= count_reg + 1'b1;
            end
            FINISH: begin
               if (!dz_reg) begin
                  hi_reg <= is_div_reg ? rem_fix : acc_reg;
                  lo_reg <= is_div_reg ? quo_fix : q_reg;
               end
            end
            default: ;
         endcase
      end
   end

   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int errors = 0;
   int checks = 0;

   mult_div_unit #(.DATA_W(32), .ITERS(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clock = ~clock;

   // Issue one start, then wait (bounded) for done; report what was seen.
   task automatic run_op(input logic m, input logic d,
                         input logic [31:0] av, input logic [31:0] bv,
                         output int cyc, output logic busy_start,
                         output logic [31:0] h, output logic [31:0] l,
                         output logic dz, output logic busy_after,
                         output logic done_after);
      @(negedge clock);
      start_mult = m; start_div = d; a = av; b = bv;
      @(posedge clock); #1;
      start_mult = 0; start_div = 0;
      a = $urandom; b = $urandom;
      busy_start = busy;
      cyc = -1;
      h = '0; l = '0; dz = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock); #1;
         if (done) begin
            cyc = i; h = hi; l = lo; dz = div_zero;
            break;
         end
      end
      @(posedge clock); #1;
      busy_after = busy;
      done_after = done;
      $display("op mult=%0b div=%0b a=%h b=%h -> cyc=%0d hi=%h lo=%h dz=%0b",
               m, d, av, bv, cyc, h, l, dz);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%0b exp=0", div_zero); end
      checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
      @(negedge clock);
      reset = 1'b1;
      $display("reset checked");
   endtask

   task automatic test_mult;
      int c; logic bs, ba, da, dz; logic [31:0] h, l;
      run_op(1, 0, 32'd7, 32'hFFFF_FFFD, c, bs, h, l, dz, ba, da);
      checks++; if (c !== 33) begin errors++; $display("FAIL mult_latency got=%0d exp=33", c); end
      checks++; if (bs !== 1'b1) begin errors++; $display("FAIL mult_busy_start got=%0b exp=1", bs); end
      checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_7x-3_hi got=%h exp=ffffffff", h); end
      checks++; if (l !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_7x-3_lo got=%h exp=ffffffeb", l); end
      checks++; if (ba !== 1'b0) begin errors++; $display("FAIL mult_busy_after got=%0b exp=0", ba); end
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL mult_done_width got=%0b exp=0", da); end
      run_op(1, 0, 32'h8000_0000, 32'h8000_0000, c, bs, h, l, dz, ba, da);
      checks++; if (h !== 32'h4000_0000) begin errors++; $display("FAIL mult_min2_hi got=%h exp=40000000", h); end
      checks++; if (l !== 32'h0) begin errors++; $display("FAIL mult_min2_lo got=%h exp=0", l); end
      run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, bs, h, l, dz, ba, da);
      checks++; if (h !== 32'h0) begin errors++; $display("FAIL mult_m1m1_hi got=%h exp=0", h); end
      checks++; if (l !== 32'h1) begin errors++; $display("FAIL mult_m1m1_lo got=%h exp=1", l); end
   endtask

   task automatic test_div;
      int c; logic bs, ba, da, dz; logic [31:0] h, l;
      run_op(0, 1, 32'hFFFF_FFF9, 32'd2, c, bs, h, l, dz, ba, da);
      checks++; if (c !== 33) begin errors++; $display("FAIL div_latency got=%0d exp=33", c); end
      checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_-7/2_lo got=%h exp=fffffffd", l); end
      checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_-7/2_hi got=%h exp=ffffffff", h); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_dz_normal got=%0b exp=0", dz); end
      run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, c, bs, h, l, dz, ba, da);
      checks++; if (l !== 32'h8000_0000) begin errors++; $display("FAIL div_min/-1_lo got=%h exp=80000000", l); end
      checks++; if (h !== 32'h0) begin errors++; $display("FAIL div_min/-1_hi got=%h exp=0", h); end
      run_op(0, 1, 32'd100, 32'd7, c, bs, h, l, dz, ba, da);
      checks++; if (l !== 32'd14) begin errors++; $display("FAIL div_100/7_lo got=%h exp=e", l); end
      checks++; if (h !== 32'd2) begin errors++; $display("FAIL div_100/7_hi got=%h exp=2", h); end
   endtask

   // Relies on hi=2, lo=14 left by the previous task.
   task automatic test_div_zero;
      int c; logic bs, ba, da, dz; logic [31:0] h, l;
      run_op(0, 1, 32'd5, 32'd0, c, bs, h, l, dz, ba, da);
      checks++; if (c !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", c); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got=%0b exp=1", dz); end
      checks++; if (h !== 32'd2 || l !== 32'd14) begin errors++; $display("FAIL dz_hold got=%h_%h exp=00000002_0000000e", h, l); end
      checks++; if (ba !== 1'b0 || da !== 1'b0 || div_zero !== 1'b0) begin
         errors++; $display("FAIL dz_after got busy=%0b done=%0b dz=%0b exp=0/0/0", ba, da, div_zero);
      end
      repeat (3) @(posedge clock);
      #1;
      checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL dz_idle_hold got=%h_%h exp=00000002_0000000e", hi, lo); end
   endtask

   task automatic test_priority_ignore;
      int c, ndone; logic bs, ba, da, dz; logic [31:0] h, l;
      run_op(1, 1, 32'd6, 32'd7, c, bs, h, l, dz, ba, da);
      checks++; if (c !== 33 || l !== 32'd42 || h !== 32'd0 || dz !== 1'b0) begin
         errors++; $display("FAIL both_start got cyc=%0d hi=%h lo=%h dz=%0b exp 33/0/2a/0", c, h, l, dz);
      end
      @(negedge clock);
      start_mult = 1; a = 32'd5; b = 32'd5;
      @(posedge clock); #1;
      start_mult = 0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      start_div = 1; a = 32'd100; b = 32'd7;
      @(posedge clock); #1;
      start_div = 0;
      ndone = 0; l = '0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clock); #1;
         if (done) begin ndone++; l = lo; end
      end
      $display("ignore-start: dones=%0d lo=%h", ndone, l);
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
      checks++; if (l !== 32'd25) begin errors++; $display("FAIL ignore_lo got=%h exp=19", l); end
   endtask

   task automatic test_reset_mid;
      int c, ndone; logic bs, ba, da, dz; logic [31:0] h, l;
      @(negedge clock);
      start_mult = 1; a = 32'h0001_2345; b = 32'h0000_0777;
      @(posedge clock); #1;
      start_mult = 0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++; $display("FAIL midreset got busy=%0b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clock); #1;
         if (done) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_nodone got=%0d exp=0", ndone); end
      run_op(1, 0, 32'd3, 32'd4, c, bs, h, l, dz, ba, da);
      checks++; if (c !== 33 || l !== 32'd12 || h !== 32'd0) begin
         errors++; $display("FAIL after_reset got cyc=%0d hi=%h lo=%h exp 33/0/c", c, h, l);
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_div_zero;
      test_priority_ignore;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
